alu_uart_interface: RTL
=======================

# alu_uart_interface

Command sequencer that drives the ALU operand/opcode loading port from a serial byte stream and returns the result to a byte transmitter. It takes three bytes from the UART receiver (operand A, operand B, opcode byte), pulses the ALU load enables, captures the ALU result and hands it to the UART transmitter with a start/done handshake. It sits between the UART RX/TX pair and the ALU in the top level.

## Interface
- NB_DATA, 8, data width of bytes, operands and result
- i_clk  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  NB_DATA  byte from receiver, valid when i_rx_done=1
- i_rx_done  in  1  single-cycle strobe, new received byte
- i_alu_result  in  NB_DATA  ALU result (combinational from ALU registers)
- i_alu_carry  in  1  ALU carry flag
- i_alu_zero  in  1  ALU zero flag
- i_tx_done  in  1  single-cycle strobe, transmitter finished current byte
- o_alu_data  out  NB_DATA  data bus to ALU i_data
- o_alu_enable_1  out  1  load operand A (one-cycle pulse)
- o_alu_enable_2  out  1  load operand B (one-cycle pulse)
- o_alu_enable_3  out  1  load opcode (one-cycle pulse; ALU uses bits [7:2])
- o_tx_data  out  NB_DATA  byte to transmitter
- o_tx_start  out  1  one-cycle pulse, start transmission of o_tx_data
- o_busy  out  1  high in every state other than GET_A, GET_B, GET_OP

## Operation
- All outputs registered. Reset: state=GET_A, o_alu_data=0, all enables=0, o_tx_data=0, o_tx_start=0, o_busy=0.
- GET_A: on i_rx_done, o_alu_data<=i_rx_data, o_alu_enable_1<=1, -> GET_B.
- GET_B: same with o_alu_enable_2, -> GET_OP.
- GET_OP: same with o_alu_enable_3, -> EXEC.
- EXEC: one cycle (ALU latches opcode at end of this cycle), -> CAPTURE.
- CAPTURE: o_tx_data<=i_alu_result, flags<={i_alu_carry,i_alu_zero}, o_tx_start<=1, -> WAIT_RES.
- WAIT_RES: on i_tx_done -> SEND_FLG if flags enabled, else GET_A.
- SEND_FLG: o_tx_data<={{NB_DATA-2{0}},carry,zero}, o_tx_start<=1, -> WAIT_FLG. WAIT_FLG: on i_tx_done -> GET_A.
- Enables are mutually exclusive; each high exactly one cycle per accepted byte; deasserted in all other cycles. o_alu_data holds last driven byte.
- Opcode not validated; undefined opcodes pass through (ALU returns 0).
- i_rx_done in EXEC/CAPTURE/WAIT_*/SEND_FLG: byte dropped, no state change.
- i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
- i_rx_done and i_tx_done in same cycle in WAIT state: tx_done taken, rx byte dropped (FSM not yet in GET_A).
- Reset mid-sequence: immediate return to reset values; partially loaded operands are not re-sent; next byte is operand A.

## Timing
- i_rx_done in cycle n (GET_x) -> enable pulse and o_alu_data valid in cycle n+1; ALU captures at end of n+1.
- Opcode i_rx_done in cycle k: o_alu_enable_3 in k+1 (EXEC), result sampled in k+2 (CAPTURE), o_tx_start high in k+3. Fixed latency 3 cycles.
- o_tx_data stable from o_tx_start until the cycle after matching i_tx_done.
- Earliest next operand A accepted: cycle after final i_tx_done.

## Configuration
- ALU_IF_FLAGS_EN defined: SEND_FLG/WAIT_FLG present; each operation transmits two bytes: result, then {000000,carry,zero}.
- Not defined: states compiled out; one result byte per operation; carry/zero inputs unused.

## Test plan
- ADD: rx 0x05, 0x03, 0x80 -> enable_1/2/3 pulses with data 0x05/0x03/0x80, o_tx_start 3 cycles after op strobe, o_tx_data=0x08.
- SUB with flags (ALU_IF_FLAGS_EN): rx 0x05, 0x05, 0x88 -> tx 0x00, then after i_tx_done tx 0x03 (carry=1, zero=1).
- Dropped byte: rx 0x0F, 0xF0, 0x90 (AND -> 0x00), extra rx_done 0xAA during WAIT_RES -> no enable pulse, next sequence starts cleanly with following byte as A.
- Reset mid-sequence: rx 0x11, 0x22, assert i_reset -> all outputs 0, state GET_A; rx 0x01, 0x02, 0x80 -> tx 0x03.
- Simultaneous i_rx_done/i_tx_done in WAIT_RES -> tx_done completes, rx byte ignored, o_busy falls next cycle.
- Back-to-back: two full ADD sequences (0x01+0x01, 0xFF+0x01) -> tx 0x02 then 0x00, no spurious o_tx_start.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Byte-serial command sequencer between a UART RX/TX pair and the ALU load port.
// Optional ALU_IF_FLAGS_EN: after the result byte, also transmit {0..0,carry,zero}.
module alu_uart_interface #(
    parameter int unsigned NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_data,
    output logic               o_alu_enable_1,
    output logic               o_alu_enable_2,
    output logic               o_alu_enable_3,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        CAPTURE,
        WAIT_RES
`ifdef ALU_IF_FLAGS_EN
        ,
        SEND_FLG,
        WAIT_FLG
`endif
    } state_t;

    state_t             state, state_next;
    logic [NB_DATA-1:0] alu_data_next;
    logic               enable_1_next, enable_2_next, enable_3_next;
    logic [NB_DATA-1:0] tx_data_next;
    logic               tx_start_next;
    logic               busy_next;

`ifdef ALU_IF_FLAGS_EN
    logic [1:0] flags, flags_next;
`else
    logic unused_flags;
    assign unused_flags = i_alu_carry ^ i_alu_zero;
`endif

    // State and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= GET_A;
            o_alu_data     <= '0;
            o_alu_enable_1 <= 1'b0;
            o_alu_enable_2 <= 1'b0;
            o_alu_enable_3 <= 1'b0;
            o_tx_data      <= '0;
            o_tx_start     <= 1'b0;
            o_busy         <= 1'b0;
`ifdef ALU_IF_FLAGS_EN
            flags          <= '0;
`endif
        end else begin
            state          <= state_next;
            o_alu_data     <= alu_data_next;
            o_alu_enable_1 <= enable_1_next;
            o_alu_enable_2 <= enable_2_next;
            o_alu_enable_3 <= enable_3_next;
            o_tx_data      <= tx_data_next;
            o_tx_start     <= tx_start_next;
            o_busy         <= busy_next;
`ifdef ALU_IF_FLAGS_EN
            flags          <= flags_next;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next    = state;
        alu_data_next = o_alu_data;
        enable_1_next = 1'b0;
        enable_2_next = 1'b0;
        enable_3_next = 1'b0;
        tx_data_next  = o_tx_data;
        tx_start_next = 1'b0;
`ifdef ALU_IF_FLAGS_EN
        flags_next    = flags;
`endif
        case (state)
            GET_A: if (i_rx_done) begin
                alu_data_next = i_rx_data;
                enable_1_next = 1'b1;
                state_next    = GET_B;
            end
            GET_B: if (i_rx_done) begin
                alu_data_next = i_rx_data;
                enable_2_next = 1'b1;
                state_next    = GET_OP;
            end
            GET_OP: if (i_rx_done) begin
                alu_data_next = i_rx_data;
                enable_3_next = 1'b1;
                state_next    = EXEC;
            end
            // ALU latches the opcode at the end of this cycle
            EXEC: state_next = CAPTURE;
            CAPTURE: begin
                tx_data_next  = i_alu_result;
                tx_start_next = 1'b1;
`ifdef ALU_IF_FLAGS_EN
                flags_next    = {i_alu_carry, i_alu_zero};
`endif
                state_next    = WAIT_RES;
            end
            WAIT_RES: if (i_tx_done) begin
`ifdef ALU_IF_FLAGS_EN
                state_next = SEND_FLG;
`else
                state_next = GET_A;
`endif
            end
`ifdef ALU_IF_FLAGS_EN
            SEND_FLG: begin
                tx_data_next  = NB_DATA'(flags);
                tx_start_next = 1'b1;
                state_next    = WAIT_FLG;
            end
            WAIT_FLG: if (i_tx_done) state_next = GET_A;
`endif
            default: state_next = GET_A;
        endcase
        busy_next = !(state_next == GET_A || state_next == GET_B || state_next == GET_OP);
    end

endmodule
